display_frame_loader: RTL and testbench

//   Write-side producer for display_memory: accepts a byte stream (from the host link receiver),

---
 rtl/display_frame_loader.sv | 208 ++++++++++++++++++++
 tb/tb_display_frame_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_frame_loader.sv
// Byte-stream to pixel loader for display_memory: packs {blue,green,red} from three
// accepted bytes, writes pixels in raster order, then toggles the bank select once per frame.
module display_frame_loader #(
  parameter int rows    = 8,
  parameter int columns = 32,
  parameter int width   = 24,
  localparam int RW = (rows > 1) ? $clog2(rows) : 1,
  localparam int CW = (columns > 1) ? $clog2(columns) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_first,
  output logic             mem_wen,
  output logic [RW-1:0]    mem_wrow,
  output logic [CW-1:0]    mem_wcol,
  output logic [width-1:0] mem_wdata,
  output logic             mem_flip,
  output logic             frame_done,
  output logic             busy,
  output logic [7:0]       err_count,
  output logic [1:0]       dbg_state
);

  // Handshake: a byte transfers on a rising clk edge where in_valid & in_ready are both high;
  // in_ready depends only on state, never on in_valid, and the source holds data until accepted.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_FLIP = 2'd2
  } state_t;

  localparam logic [RW-1:0] ROW_LAST = RW'(rows - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(columns - 1);

  generate
    if (width != 24) begin : g_bad_width
      $error("display_frame_loader: width must be 24");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_idx;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [7:0]       r_red;
  logic [7:0]       r_green;
  logic             r_wen;
  logic [RW-1:0]    r_wrow;
  logic [CW-1:0]    r_wcol;
  logic [width-1:0] r_wdata;
  logic             r_flip;
  logic             r_done;
  logic [7:0]       r_err;
  logic             w_accept;
  logic             w_last_pix;
  logic             w_ready;
  logic             w_busy;

  assign w_accept   = in_valid & w_ready;
  assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && in_first) w_next_state = S_RECV;
      end
      S_RECV: begin
        if (w_accept && !in_first && (r_idx == 2'd2) && w_last_pix) w_next_state = S_FLIP;
      end
      S_FLIP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_ready = 1'b1;
    w_busy  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
      end
      S_RECV: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
      end
      S_FLIP: begin
        w_ready = 1'b0;
        w_busy  = 1'b1;
      end
      default: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  // Pixel packing, raster counters, write port, flip and error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= 2'd0;
      r_row   <= '0;
      r_col   <= '0;
      r_red   <= 8'd0;
      r_green <= 8'd0;
      r_wen   <= 1'b0;
      r_wrow  <= '0;
      r_wcol  <= '0;
      r_wdata <= '0;
      r_flip  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 8'd0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && in_first) begin
            r_red <= in_data;
            r_idx <= 2'd1;
            r_row <= '0;
            r_col <= '0;
          end
        end
        S_RECV: begin
          if (w_accept) begin
            if (in_first) begin
              // Abort: restart at pixel (0,0); already-written pixels stay in the back bank.
              if (r_err != 8'hFF) r_err <= r_err + 8'd1;
              r_red <= in_data;
              r_idx <= 2'd1;
              r_row <= '0;
              r_col <= '0;
            end else begin
              case (r_idx)
                2'd0: begin
                  r_red <= in_data;
                  r_idx <= 2'd1;
                end
                2'd1: begin
                  r_green <= in_data;
                  r_idx   <= 2'd2;
                end
                default: begin
                  r_wen   <= 1'b1;
                  r_wrow  <= r_row;
                  r_wcol  <= r_col;
                  r_wdata <= {in_data, r_green, r_red};
                  r_idx   <= 2'd0;
                  if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                  end else begin
                    r_col <= r_col + CW'(1);
                  end
                end
              endcase
            end
          end
        end
        S_FLIP: begin
          // The final pixel's write occupies this cycle; the bank swaps after it.
          r_flip <= ~r_flip;
          r_done <= 1'b1;
          r_row  <= '0;
          r_col  <= '0;
          r_idx  <= 2'd0;
        end
        default: begin
          r_idx <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready   = w_ready;
  assign busy       = w_busy;
  assign mem_wen    = r_wen;
  assign mem_wrow   = r_wrow;
  assign mem_wcol   = r_wcol;
  assign mem_wdata  = r_wdata;
  assign mem_flip   = r_flip;
  assign frame_done = r_done;
  assign err_count  = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_display_frame_loader.sv
// Directed bench for display_frame_loader: reset, packing latency, full frames, aborts,
// back-to-back frames across the flip cycle, error saturation and asynchronous reset.
module tb_display_frame_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        in_first = 1'b0;
  logic        mem_wen;
  logic [2:0]  mem_wrow;
  logic [4:0]  mem_wcol;
  logic [23:0] mem_wdata;
  logic        mem_flip;
  logic        frame_done;
  logic        busy;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int consec_cnt = 0;
  int stall_sum = 0;
  logic prev_wen = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] wr_q[$];
  logic        done_flip_q[$];

  display_frame_loader #(.rows(8), .columns(32), .width(24)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .mem_wen(mem_wen), .mem_wrow(mem_wrow), .mem_wcol(mem_wcol),
    .mem_wdata(mem_wdata), .mem_flip(mem_flip), .frame_done(frame_done), .busy(busy),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog sim_time=%0t limit=1ms", $time);
    $fatal(1, "watchdog expired");
  end

  // Write-port and frame_done monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mem_wen) begin
      wr_q.push_back({mem_wrow, mem_wcol, mem_wdata});
      if (prev_wen) consec_cnt++;
    end
    prev_wen = mem_wen;
    if (frame_done) begin
      done_cnt++;
      done_flip_q.push_back(mem_flip);
    end
  end

  // Driver tasks: every task starts and ends 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] d, input logic f);
    int s;
    s = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    while (in_ready !== 1'b1 && s < 20) begin
      @(posedge clk);
      #1;
      s++;
    end
    if (s >= 20) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end
    stall_sum += s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_first = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    exp_q.delete();
    done_flip_q.delete();
    done_cnt   = 0;
    consec_cnt = 0;
    stall_sum  = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_first = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pix(input int p, input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    return {3'(p / 32), 5'(p % 32), b, g, r};
  endfunction

  // Tests
  task automatic test_reset();
    #1;
    total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL rst_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (mem_wen !== 1'b0)     begin bad++; $display("FAIL rst_wen got=%b want=0", mem_wen); end
    total++; if (mem_wrow !== 3'd0)    begin bad++; $display("FAIL rst_wrow got=%0d want=0", mem_wrow); end
    total++; if (mem_wcol !== 5'd0)    begin bad++; $display("FAIL rst_wcol got=%0d want=0", mem_wcol); end
    total++; if (mem_wdata !== 24'd0)  begin bad++; $display("FAIL rst_wdata got=%h want=0", mem_wdata); end
    total++; if (mem_flip !== 1'b0)    begin bad++; $display("FAIL rst_flip got=%b want=0", mem_flip); end
    total++; if (frame_done !== 1'b0)  begin bad++; $display("FAIL rst_done got=%b want=0", frame_done); end
    total++; if (err_count !== 8'd0)   begin bad++; $display("FAIL rst_err got=%0d want=0", err_count); end
    total++; if (dbg_state !== 2'd0)   begin bad++; $display("FAIL rst_state got=%0d want=0", dbg_state); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle_drop();
    clear_mon();
    for (int k = 0; k < 5; k++) send_byte(8'(k * 3 + 1), 1'b0);
    idle(2);
    total++; if (stall_sum != 0)     begin bad++; $display("FAIL idle_ready stalls=%0d want=0", stall_sum); end
    total++; if (wr_q.size() != 0)   begin bad++; $display("FAIL idle_wen writes=%0d want=0", wr_q.size()); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d want=0", dbg_state); end
  endtask

  task automatic test_single_pixel();
    clear_mon();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL sp_early_wen got=%b want=0", mem_wen); end
    total++; if (busy !== 1'b1)    begin bad++; $display("FAIL sp_busy got=%b want=1", busy); end
    send_byte(8'h33, 1'b0);
    total++; if (mem_wen !== 1'b1)         begin bad++; $display("FAIL sp_wen got=%b want=1", mem_wen); end
    total++; if (mem_wdata !== 24'h332211) begin bad++; $display("FAIL sp_wdata got=%h want=332211", mem_wdata); end
    total++; if (mem_wrow !== 3'd0)        begin bad++; $display("FAIL sp_wrow got=%0d want=0", mem_wrow); end
    total++; if (mem_wcol !== 5'd0)        begin bad++; $display("FAIL sp_wcol got=%0d want=0", mem_wcol); end
    idle(1);
    total++; if (mem_wen !== 1'b0)         begin bad++; $display("FAIL sp_wen_low got=%b want=0", mem_wen); end
    total++; if (mem_wdata !== 24'h332211) begin bad++; $display("FAIL sp_hold got=%h want=332211", mem_wdata); end
  endtask

  task automatic test_full_frame();
    clear_mon();
    for (int k = 0; k < 768; k++) send_byte(8'(k), k == 0);
    idle(4);
    for (int p = 0; p < 256; p++) exp_q.push_back(pix(p, 8'(3 * p), 8'(3 * p + 1), 8'(3 * p + 2)));
    total++;
    if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL ff_count got=%0d want=%0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL ff_pix%0d got=%h want=%h", i, wr_q[i], exp_q[i]); end
    end
    total++; if (done_cnt != 1)      begin bad++; $display("FAIL ff_done got=%0d want=1", done_cnt); end
    total++; if (mem_flip !== 1'b1)  begin bad++; $display("FAIL ff_flip got=%b want=1", mem_flip); end
    total++;
    if (done_flip_q.size() != 1 || done_flip_q[0] !== 1'b1) begin
      bad++; $display("FAIL ff_done_flip pulses=%0d want flip=1 on one pulse", done_flip_q.size());
    end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL ff_err got=%0d want=0", err_count); end
    total++; if (consec_cnt != 0)    begin bad++; $display("FAIL ff_consec got=%0d want=0", consec_cnt); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL ff_busy got=%b want=0", busy); end
  endtask

  task automatic test_abort();
    clear_mon();
    for (int k = 0; k < 30; k++) send_byte(8'(k + 100), k == 0);
    idle(2);
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL ab_busy got=%b want=1", busy); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL ab_err_pre got=%0d want=0", err_count); end
    send_byte(8'd0, 1'b1);
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL ab_err got=%0d want=1", err_count); end
    total++; if (mem_flip !== 1'b1)  begin bad++; $display("FAIL ab_noflip got=%b want=1", mem_flip); end
    for (int k = 1; k < 768; k++) send_byte(8'(k), 1'b0);
    idle(4);
    for (int p = 0; p < 10; p++) exp_q.push_back(pix(p, 8'(3 * p + 100), 8'(3 * p + 101), 8'(3 * p + 102)));
    for (int p = 0; p < 256; p++) exp_q.push_back(pix(p, 8'(3 * p), 8'(3 * p + 1), 8'(3 * p + 2)));
    total++;
    if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL ab_count got=%0d want=%0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL ab_pix%0d got=%h want=%h", i, wr_q[i], exp_q[i]); end
    end
    total++; if (done_cnt != 1)      begin bad++; $display("FAIL ab_done got=%0d want=1", done_cnt); end
    total++; if (mem_flip !== 1'b0)  begin bad++; $display("FAIL ab_flip got=%b want=0", mem_flip); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL ab_err_end got=%0d want=1", err_count); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    for (int k = 0; k < 768; k++) send_byte(8'(k) ^ 8'h5A, k == 0);
    for (int k = 0; k < 768; k++) send_byte(8'(k + 7), k == 0);
    idle(4);
    for (int p = 0; p < 256; p++)
      exp_q.push_back(pix(p, 8'(3 * p) ^ 8'h5A, 8'(3 * p + 1) ^ 8'h5A, 8'(3 * p + 2) ^ 8'h5A));
    for (int p = 0; p < 256; p++) exp_q.push_back(pix(p, 8'(3 * p + 7), 8'(3 * p + 8), 8'(3 * p + 9)));
    total++; if (stall_sum != 1) begin bad++; $display("FAIL b2b_stall got=%0d want=1", stall_sum); end
    total++;
    if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_pix%0d got=%h want=%h", i, wr_q[i], exp_q[i]); end
    end
    total++; if (done_cnt != 2)     begin bad++; $display("FAIL b2b_done got=%0d want=2", done_cnt); end
    total++;
    if (done_flip_q.size() != 2 || done_flip_q[0] !== 1'b1 || done_flip_q[1] !== 1'b0) begin
      bad++; $display("FAIL b2b_flip_seq pulses=%0d want 1 then 0", done_flip_q.size());
    end
    total++; if (mem_flip !== 1'b0) begin bad++; $display("FAIL b2b_flip got=%b want=0", mem_flip); end
    total++; if (consec_cnt != 0)   begin bad++; $display("FAIL b2b_consec got=%0d want=0", consec_cnt); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL b2b_err got=%0d want=1", err_count); end
  endtask

  task automatic test_err_saturate();
    clear_mon();
    for (int k = 0; k < 260; k++) send_byte(8'(k), 1'b1);
    idle(1);
    total++; if (err_count !== 8'd255) begin bad++; $display("FAIL sat_err got=%0d want=255", err_count); end
    total++; if (wr_q.size() != 0)     begin bad++; $display("FAIL sat_wen writes=%0d want=0", wr_q.size()); end
    total++; if (mem_flip !== 1'b0)    begin bad++; $display("FAIL sat_flip got=%b want=0", mem_flip); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    for (int k = 0; k < 289; k++) send_byte(8'(k), k == 0);
    in_valid = 1'b0;
    in_first = 1'b0;
    #2;
    total++;
    if (mem_wrow !== 3'd2 || mem_wcol !== 5'd31) begin
      bad++; $display("FAIL rm_pre_pos got=%0d,%0d want=2,31", mem_wrow, mem_wcol);
    end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rm_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL rm_ready got=%b want=1", in_ready); end
    total++; if (mem_wrow !== 3'd0)   begin bad++; $display("FAIL rm_wrow got=%0d want=0", mem_wrow); end
    total++; if (mem_wcol !== 5'd0)   begin bad++; $display("FAIL rm_wcol got=%0d want=0", mem_wcol); end
    total++; if (mem_wdata !== 24'd0) begin bad++; $display("FAIL rm_wdata got=%h want=0", mem_wdata); end
    total++; if (err_count !== 8'd0)  begin bad++; $display("FAIL rm_err got=%0d want=0", err_count); end
    total++; if (dbg_state !== 2'd0)  begin bad++; $display("FAIL rm_state got=%0d want=0", dbg_state); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_q.delete();
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    idle(2);
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL rm_nowen writes=%0d want=0", wr_q.size()); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rm_idle_busy got=%b want=0", busy); end
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b0);
    idle(2);
    total++;
    if (wr_q.size() != 1 || wr_q[0] !== {3'd0, 5'd0, 24'hC3B2A1}) begin
      bad++; $display("FAIL rm_first_pix writes=%0d want one write of C3B2A1 at 0,0", wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_idle_drop();
    test_single_pixel();
    do_reset();
    test_full_frame();
    test_abort();
    test_back_to_back();
    test_err_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
